// File: rtl/ps2_command_out.sv
// ps2_command_out
// Host-to-device PS/2 command transmitter. Inhibits the PS/2 clock for the
// request-to-send hold time, drives the start bit, shifts the byte out LSB
// first on device clock falling edges, appends odd parity and the stop bit,
// then samples the device acknowledge on the following rising edge.
//
// Optional feature: define PS2_COMMAND_OUT_TIMEOUT_EN to enable the
// 15 ms first-clock timeout and the 2 ms frame-to-ack timeout. Without it
// the waiting states wait indefinitely and only a missing ack reports an
// error.
//
// PS2_CLK and PS2_DAT are open-drain: they are only ever driven low or
// released to high-Z.

module ps2_command_out #(
   parameter int CLOCK_CYCLES_FOR_101US = 5050,
   parameter int CLOCK_CYCLES_FOR_15MS  = 750000,
   parameter int CLOCK_CYCLES_FOR_2MS   = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] the_command,
   input  logic       send_command,
   input  logic       ps2_clk_posedge,
   input  logic       ps2_clk_negedge,
   input  logic       ps2_data,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT,
   output logic       busy,
   output logic       command_was_sent,
   output logic       error_communication_timed_out
);

   localparam logic [3:0] S_IDLE            = 4'd0;
   localparam logic [3:0] S_INITIATE        = 4'd1;
   localparam logic [3:0] S_WAIT_FOR_CLOCK  = 4'd2;
   localparam logic [3:0] S_TRANSMIT_DATA   = 4'd3;
   localparam logic [3:0] S_TRANSMIT_PARITY = 4'd4;
   localparam logic [3:0] S_TRANSMIT_STOP   = 4'd5;
   localparam logic [3:0] S_RECEIVE_ACK     = 4'd6;
   localparam logic [3:0] S_COMMAND_SENT    = 4'd7;
   localparam logic [3:0] S_ERROR           = 4'd8;

`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
   // One counter is shared by the inhibit hold and both timeouts, so it must
   // reach the largest of the three limits.
   localparam int CNT_MAX_A = (CLOCK_CYCLES_FOR_101US > CLOCK_CYCLES_FOR_15MS) ?
                              CLOCK_CYCLES_FOR_101US : CLOCK_CYCLES_FOR_15MS;
   localparam int CNT_MAX   = (CNT_MAX_A > CLOCK_CYCLES_FOR_2MS) ?
                              CNT_MAX_A : CLOCK_CYCLES_FOR_2MS;
`else
   localparam int CNT_MAX   = CLOCK_CYCLES_FOR_101US;
`endif
   localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(CLOCK_CYCLES_FOR_101US);
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
   localparam logic [CW-1:0] FIRST_CLK_LAST = CW'(CLOCK_CYCLES_FOR_15MS);
   localparam logic [CW-1:0] ACK_LAST       = CW'(CLOCK_CYCLES_FOR_2MS);
`endif

   logic [3:0]    state_reg, state_next;
   logic [CW-1:0] counter_reg, counter_next;
   logic [2:0]    index_reg, index_next;
   logic [7:0]    command_reg, command_next;
   // A new transfer may start only after send_command has been observed low,
   // so a request still held from a previous (or reset-aborted) transfer
   // cannot retrigger on its own.
   logic          armed_reg, armed_next;
   logic          clk_low_reg, clk_low_next;
   logic          dat_low_reg, dat_low_next;
   logic          busy_reg;
   logic          command_was_sent_reg;
   logic          error_reg;
   logic          parity_next;

   // Next-state, counter, bit index and command register logic.
   always_comb begin
      state_next   = state_reg;
      counter_next = counter_reg;
      index_next   = index_reg;
      command_next = command_reg;
      armed_next   = armed_reg;

      if (!send_command) begin
         armed_next = 1'b1;
      end

      case (state_reg)
         S_IDLE: begin
            counter_next = '0;
            index_next   = '0;
            if (send_command && armed_reg) begin
               state_next   = S_INITIATE;
               command_next = the_command;
               armed_next   = 1'b0;
            end
         end

         S_INITIATE: begin
            if (counter_reg == HOLD_LAST) begin
               state_next   = S_WAIT_FOR_CLOCK;
               counter_next = '0;
            end else begin
               counter_next = counter_reg + CW'(1);
            end
         end

         S_WAIT_FOR_CLOCK: begin
            if (ps2_clk_negedge) begin
               state_next   = S_TRANSMIT_DATA;
               index_next   = '0;
               counter_next = '0;
            end
`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
            else if (counter_reg == FIRST_CLK_LAST) begin
               state_next = S_ERROR;
            end else begin
               counter_next = counter_reg + CW'(1);
            end
`endif
         end

         S_TRANSMIT_DATA: begin
            if (ps2_clk_negedge) begin
               if (index_reg == 3'd7) begin
                  state_next = S_TRANSMIT_PARITY;
               end else begin
                  index_next = index_reg + 3'd1;
               end
            end
         end

         S_TRANSMIT_PARITY: begin
            if (ps2_clk_negedge) begin
               state_next = S_TRANSMIT_STOP;
            end
         end

         S_TRANSMIT_STOP: begin
            if (ps2_clk_negedge) begin
               state_next = S_RECEIVE_ACK;
            end
         end

         S_RECEIVE_ACK: begin
            if (ps2_clk_posedge) begin
               state_next = ps2_data ? S_ERROR : S_COMMAND_SENT;
            end
         end

         S_COMMAND_SENT, S_ERROR: begin
            if (!send_command) begin
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

`ifdef PS2_COMMAND_OUT_TIMEOUT_EN
      // Frame-to-ack timer: runs from leaving WAIT_FOR_CLOCK until the ack.
      if ((state_reg == S_TRANSMIT_DATA)   || (state_reg == S_TRANSMIT_PARITY) ||
          (state_reg == S_TRANSMIT_STOP)   || (state_reg == S_RECEIVE_ACK)) begin
         if (counter_reg == ACK_LAST) begin
            if (state_next != S_COMMAND_SENT) begin
               state_next = S_ERROR;
            end
         end else begin
            counter_next = counter_reg + CW'(1);
         end
      end
`endif
   end

   // Line drive decode from the next state so the open-drain enables are
   // registered and glitch-free on the PS/2 wires.
   always_comb begin
      parity_next  = ~^command_next;
      clk_low_next = (state_next == S_INITIATE);
      dat_low_next = 1'b0;
      case (state_next)
         S_WAIT_FOR_CLOCK:  dat_low_next = 1'b1;
         S_TRANSMIT_DATA:   dat_low_next = ~command_next[index_next];
         S_TRANSMIT_PARITY: dat_low_next = ~parity_next;
         default:           dat_low_next = 1'b0;
      endcase
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg            <= S_IDLE;
         counter_reg          <= '0;
         index_reg            <= '0;
         command_reg          <= '0;
         armed_reg            <= 1'b0;
         clk_low_reg          <= 1'b0;
         dat_low_reg          <= 1'b0;
         busy_reg             <= 1'b0;
         command_was_sent_reg <= 1'b0;
         error_reg            <= 1'b0;
      end else begin
         state_reg            <= state_next;
         counter_reg          <= counter_next;
         index_reg            <= index_next;
         command_reg          <= command_next;
         armed_reg            <= armed_next;
         clk_low_reg          <= clk_low_next;
         dat_low_reg          <= dat_low_next;
         busy_reg             <= (state_next != S_IDLE);
         command_was_sent_reg <= (state_next == S_COMMAND_SENT);
         error_reg            <= (state_next == S_ERROR);
      end
   end

   assign PS2_CLK = clk_low_reg ? 1'b0 : 1'bz;
   assign PS2_DAT = dat_low_reg ? 1'b0 : 1'bz;

   assign busy                          = busy_reg;
   assign command_was_sent              = command_was_sent_reg;
   assign error_communication_timed_out = error_reg;

endmodule

// File: doc/ps2_command_out.md
PS2_COMMAND_OUT -- requirements
Module: ps2_command_out

Interface
REQ-001 Parameter CLOCK_CYCLES_FOR_101US, default 5050: host clock-inhibit hold time in clk cycles.
REQ-002 Parameter CLOCK_CYCLES_FOR_15MS, default 750000: timeout for the device's first clock edge.
REQ-003 Parameter CLOCK_CYCLES_FOR_2MS, default 100000: timeout from the first device clock edge to the ack.
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 the_command  input  8  byte to transmit; sampled only when the command is accepted.
REQ-007 send_command  input  1  level request; held high until a completion flag is seen.
REQ-008 ps2_clk_posedge  input  1  one-cycle pulse on a synchronised PS2 clock rising edge.
REQ-009 ps2_clk_negedge  input  1  one-cycle pulse on a synchronised PS2 clock falling edge.
REQ-010 ps2_data  input  1  synchronised PS2 data line level.
REQ-011 PS2_CLK  inout  1  open-drain: driven 0 or high-Z, never driven 1.
REQ-012 PS2_DAT  inout  1  open-drain: driven 0 or high-Z, never driven 1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 command_was_sent  output  1  device acknowledged the byte.
REQ-015 error_communication_timed_out  output  1  timeout or missing ack.

Function
REQ-016 States: IDLE, INITIATE, WAIT_FOR_CLOCK, TRANSMIT_DATA, TRANSMIT_PARITY, TRANSMIT_STOP, RECEIVE_ACK, COMMAND_SENT, ERROR.
REQ-017 IDLE: send_command=1 -> INITIATE next cycle; the_command latched into the command register in that same cycle.
REQ-018 INITIATE: PS2_CLK driven 0, PS2_DAT high-Z; the counter increments each cycle; on count == CLOCK_CYCLES_FOR_101US -> WAIT_FOR_CLOCK.
REQ-019 WAIT_FOR_CLOCK: PS2_CLK high-Z, PS2_DAT driven 0 (start bit); ps2_clk_negedge -> TRANSMIT_DATA with bit index 0.
REQ-020 TRANSMIT_DATA: PS2_DAT = 0 if command[index]==0, else high-Z, LSB first; each ps2_clk_negedge increments the index; negedge at index 7 -> TRANSMIT_PARITY.
REQ-021 TRANSMIT_PARITY: drive odd parity (XNOR-reduce of the byte; 0 -> drive low, 1 -> high-Z); ps2_clk_negedge -> TRANSMIT_STOP.
REQ-022 TRANSMIT_STOP: PS2_DAT high-Z (stop=1); ps2_clk_negedge -> RECEIVE_ACK.
REQ-023 RECEIVE_ACK: both lines high-Z.
- ps2_clk_posedge with ps2_data==0 -> COMMAND_SENT.
- ps2_clk_posedge with ps2_data==1 -> ERROR.
REQ-024 COMMAND_SENT and ERROR SHALL hold their flag high while send_command==1; send_command==0 -> IDLE, with the flag low on the following cycle.
REQ-025 Both flags SHALL NOT be high together; both are registered and low in all other states.
REQ-026 Pulses on ps2_clk_posedge or ps2_clk_negedge in IDLE SHALL be ignored.
REQ-027 send_command deasserted mid-transfer SHALL NOT abort; the frame completes and the result flag shows for at least one cycle before IDLE.
REQ-028 If send_command is still high on return to IDLE, a new transfer SHALL NOT start until send_command has been seen low.

Reset
REQ-029 reset SHALL force IDLE, zero the counters, index and command register, release both lines (high-Z), and clear busy and both flags; it takes priority over all inputs, including mid-frame.

Configuration
REQ-030 Macro PS2_COMMAND_OUT_TIMEOUT_EN defined:
- WAIT_FOR_CLOCK longer than CLOCK_CYCLES_FOR_15MS cycles -> ERROR.
- More than CLOCK_CYCLES_FOR_2MS cycles from leaving WAIT_FOR_CLOCK to the ack -> ERROR.
- Both lines are released on entering ERROR.
REQ-031 Macro undefined: no timeout counters; waiting states wait indefinitely; only a missing ack reaches ERROR.

Verification
REQ-032 Command 0xF4, device clocks and acks -> PS2_DAT shows start 0, bits 0,0,1,0,1,1,1,1, parity 0 (driven low), stop high-Z; command_was_sent=1; busy=0 after send_command drops.
REQ-033 Command 0xFF -> parity bit high-Z (1); 0x00 -> parity high-Z (1); 0x01 -> parity driven low (0).
REQ-034 Timing -> PS2_CLK low for exactly CLOCK_CYCLES_FOR_101US+1 cycles after send_command is accepted.
REQ-035 ps2_data=1 at the ack posedge -> error_communication_timed_out=1 and command_was_sent=0.
REQ-036 With the macro, no device clock -> error after CLOCK_CYCLES_FOR_101US + CLOCK_CYCLES_FOR_15MS cycles; without it -> busy stays 1.
REQ-037 reset pulsed after data bit 3 -> next cycle IDLE, lines high-Z, flags 0; a subsequent command transmits correctly.
